// File: rtl/sbst_sig_pkg.sv
// Shared definitions for the SBST signature slave: register offsets, FSM states,
// default MISR polynomial/seed and the byte-enable mask helper.
package sbst_sig_pkg;

    localparam logic [5:0] OFF_SIG     = 6'h00;
    localparam logic [5:0] OFF_SIG_CLR = 6'h04;
    localparam logic [5:0] OFF_CKPT    = 6'h08;
    localparam logic [5:0] OFF_TSTAMP  = 6'h0C;
    localparam logic [5:0] OFF_EXIT    = 6'h10;
    localparam logic [5:0] OFF_CYCLE   = 6'h14;

    localparam logic [31:0] MISR_POLY_DEF = 32'h04C1_1DB7;
    localparam logic [31:0] MISR_SEED_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/sbst_misr.sv
// Signature register: shift-with-polynomial-feedback MISR folding in byte-masked data,
// with a synchronous load-seed control that takes priority over an update.
module sbst_misr
    import sbst_sig_pkg::*;
#(
    parameter logic [31:0] POLY = MISR_POLY_DEF,
    parameter logic [31:0] SEED = MISR_SEED_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        upd_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  be_i,
    output logic [31:0] sig_o
);

    logic [31:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr_i) begin
            sig_d = SEED;
        end else if (upd_i) begin
            sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ (data_i & be_mask(be_i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= SEED;
        else        sig_q <= sig_d;
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/sbst_sig_slave.sv
// Memory-mapped SBST result collector: MISR signature, checkpoint counter/timestamp,
// sticky exit code and free-running cycle counter behind a req/gnt/rvalid data port.
module sbst_sig_slave
    import sbst_sig_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0030_0000,
    parameter int unsigned GNT_WAIT  = 0,
    parameter logic [31:0] MISR_POLY = MISR_POLY_DEF,
    parameter logic [31:0] MISR_SEED = MISR_SEED_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o,
    output logic [31:0] sig_o,
    output logic [15:0] ckpt_cnt_o
);

    // The load cycle itself counts as the first wait cycle, so gnt lands GNT_WAIT cycles after req.
    localparam logic [3:0] WAIT_M1 = (GNT_WAIT == 0) ? 4'd0 : 4'(GNT_WAIT - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt;
    logic        rvalid_q, err_q;
    logic [31:0] rdata_q;
    logic [15:0] ckpt_q;
    logic [31:0] tstamp_q, cycle_q;
    logic        exit_valid_q;
    logic [31:0] exit_value_q;

    logic [31:0] off_full;
    logic [5:0]  off;
    logic        acc_err;
    logic [31:0] rd_val;
    logic        wr_ok, misr_upd, misr_clr, ckpt_wr, exit_wr;

    always_comb begin
        gnt     = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                if (data_req_i) begin
                    if (GNT_WAIT == 0) begin
                        gnt     = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = WAIT_M1;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!data_req_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    gnt     = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Decode the live bus; its result only matters in the grant cycle.
    assign off_full = data_addr_i - BASE_ADDR;
    assign off      = off_full[5:0];

    always_comb begin
        acc_err = 1'b1;
        rd_val  = 32'h0;
        if (off_full < 32'd64 && data_addr_i[1:0] == 2'b00) begin
            case (off)
                OFF_SIG:     begin acc_err = 1'b0;       rd_val = sig_o;        end
                OFF_SIG_CLR: acc_err = ~data_we_i;
                OFF_CKPT:    acc_err = ~data_we_i;
                OFF_TSTAMP:  begin acc_err = data_we_i;  rd_val = tstamp_q;     end
                OFF_EXIT:    begin acc_err = 1'b0;       rd_val = exit_value_q; end
                OFF_CYCLE:   begin acc_err = data_we_i;  rd_val = cycle_q;      end
                default:     acc_err = 1'b1;
            endcase
        end
    end

    assign wr_ok    = gnt & ~acc_err & data_we_i;
    assign misr_upd = wr_ok & (off == OFF_SIG);
    assign misr_clr = wr_ok & (off == OFF_SIG_CLR);
    assign ckpt_wr  = wr_ok & (off == OFF_CKPT);
    assign exit_wr  = wr_ok & (off == OFF_EXIT);

    sbst_misr #(
        .POLY (MISR_POLY),
        .SEED (MISR_SEED)
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (misr_clr),
        .upd_i  (misr_upd),
        .data_i (data_wdata_i),
        .be_i   (data_be_i),
        .sig_o  (sig_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            rvalid_q     <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= 32'h0;
            ckpt_q       <= 16'h0;
            tstamp_q     <= 32'h0;
            cycle_q      <= 32'h0;
            exit_valid_q <= 1'b0;
            exit_value_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cycle_q  <= cycle_q + 32'd1;
            rvalid_q <= gnt;
            err_q    <= gnt & acc_err;
            rdata_q  <= (gnt && !acc_err && !data_we_i) ? rd_val : 32'h0;
            if (ckpt_wr) begin
                if (ckpt_q != 16'hFFFF) ckpt_q <= ckpt_q + 16'd1;
                tstamp_q <= cycle_q;
            end
            if (exit_wr && !exit_valid_q) begin
                exit_valid_q <= 1'b1;
                exit_value_q <= data_wdata_i;
            end
        end
    end

    assign data_gnt_o    = gnt;
    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign data_err_o    = err_q;
    assign exit_valid_o  = exit_valid_q;
    assign exit_value_o  = exit_value_q;
    assign ckpt_cnt_o    = ckpt_q;

endmodule

// File: tb/tb_sbst_sig_slave.sv
// Bench for sbst_sig_slave: directed and random bus traffic against a register-level model,
// plus a second instance with GNT_WAIT=3 for grant latency and request abort.
module tb_sbst_sig_slave;

    localparam logic [31:0] BASE = 32'h0030_0000;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;
    localparam logic [31:0] SEED = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req = 0, we = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [3:0]  be = 0;
    logic        gnt, rvalid, err, exv;
    logic [31:0] rdata, exval, sig;
    logic [15:0] ckpt;

    logic        req1 = 0, we1 = 0;
    logic [31:0] addr1 = 0, wdata1 = 0;
    logic [3:0]  be1 = 0;
    logic        gnt1, rvalid1, err1, exv1;
    logic [31:0] rdata1, exval1, sig1;
    logic [15:0] ckpt1;

    sbst_sig_slave #(.BASE_ADDR(BASE), .GNT_WAIT(0), .MISR_POLY(POLY), .MISR_SEED(SEED)) dut (
        .clk(clk), .rst_n(rst_n), .data_req_i(req), .data_addr_i(addr), .data_we_i(we),
        .data_be_i(be), .data_wdata_i(wdata), .data_gnt_o(gnt), .data_rvalid_o(rvalid),
        .data_rdata_o(rdata), .data_err_o(err), .exit_valid_o(exv), .exit_value_o(exval),
        .sig_o(sig), .ckpt_cnt_o(ckpt)
    );

    sbst_sig_slave #(.BASE_ADDR(BASE), .GNT_WAIT(3), .MISR_POLY(POLY), .MISR_SEED(SEED)) dut_w3 (
        .clk(clk), .rst_n(rst_n), .data_req_i(req1), .data_addr_i(addr1), .data_we_i(we1),
        .data_be_i(be1), .data_wdata_i(wdata1), .data_gnt_o(gnt1), .data_rvalid_o(rvalid1),
        .data_rdata_o(rdata1), .data_err_o(err1), .exit_valid_o(exv1), .exit_value_o(exval1),
        .sig_o(sig1), .ckpt_cnt_o(ckpt1)
    );

    int vectors = 0;
    int miscompares = 0;

    // Rising edges seen since reset release: the value CYCLE must hold.
    logic [31:0] tb_cyc = 0;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;

    logic [31:0] m_sig, m_tstamp, m_exval;
    logic [15:0] m_ckpt;
    logic        m_exv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sig = SEED; m_ckpt = 0; m_tstamp = 0; m_exv = 0; m_exval = 0;
    endtask

    // Register-level effect of one granted access; cyc is CYCLE during the grant cycle.
    task automatic model_xact(input logic w, input logic [31:0] a, input logic [3:0] b,
                              input logic [31:0] d, input logic [31:0] cyc,
                              output logic e, output logic [31:0] rd);
        logic [31:0] off, mask;
        off = a - BASE;
        e = 1; rd = 0; mask = 0;
        for (int i = 0; i < 4; i++) if (b[i]) mask[8*i +: 8] = 8'hFF;
        if (off < 64 && a[1:0] == 2'b00) begin
            case (off)
                0:  begin
                        e = 0;
                        if (w) m_sig = (m_sig << 1) ^ (m_sig[31] ? POLY : 32'h0) ^ (d & mask);
                        else   rd = m_sig;
                    end
                4:  if (w) begin e = 0; m_sig = SEED; end
                8:  if (w) begin e = 0; if (m_ckpt != 16'hFFFF) m_ckpt++; m_tstamp = cyc; end
                12: if (!w) begin e = 0; rd = m_tstamp; end
                16: begin
                        e = 0;
                        if (!w) rd = m_exval;
                        else if (!m_exv) begin m_exv = 1; m_exval = d; end
                    end
                20: if (!w) begin e = 0; rd = cyc; end
                default: ;
            endcase
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".sig"}, sig, m_sig);
        chk({tag, ".ckpt"}, {16'h0, ckpt}, {16'h0, m_ckpt});
        chk({tag, ".exv"}, {31'h0, exv}, {31'h0, m_exv});
        chk({tag, ".exval"}, exval, m_exval);
    endtask

    task automatic xact(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input string tag);
        logic e;
        logic [31:0] rd;
        @(negedge clk);
        req = 1; we = w; addr = a; be = b; wdata = d;
        #1;
        chk({tag, ".gnt"}, {31'h0, gnt}, 32'h1);
        model_xact(w, a, b, d, tb_cyc, e, rd);
        @(posedge clk);
        #1;
        req = 0; we = 0; addr = 0; be = 0; wdata = 0;
        @(negedge clk);
        chk({tag, ".rvalid"}, {31'h0, rvalid}, 32'h1);
        chk({tag, ".err"}, {31'h0, err}, {31'h0, e});
        chk({tag, ".rdata"}, rdata, rd);
        check_state(tag);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] cyc, offs[12];
        model_reset();

        // Reset values while rst_n is held low
        #2;
        chk("rst.gnt", {31'h0, gnt}, 32'h0);
        chk("rst.rvalid", {31'h0, rvalid}, 32'h0);
        chk("rst.err", {31'h0, err}, 32'h0);
        chk("rst.rdata", rdata, 32'h0);
        check_state("rst");
        chk("rst.w3.rvalid", {31'h0, rvalid1}, 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;

        // Signature accumulation and readback
        xact(1, BASE + 32'h00, 4'hF, 32'h1234_5678, "sig1");
        chk("sig1.const", sig, 32'h1234_5678);
        xact(1, BASE + 32'h00, 4'hF, 32'h0000_0001, "sig2");
        chk("sig2.const", sig, 32'h2468_ACF1);
        xact(0, BASE + 32'h00, 4'hF, 32'h0, "sig_rd");

        // Byte-masked update from seed, then clear
        xact(1, BASE + 32'h04, 4'h0, 32'hDEAD_BEEF, "clr1");
        xact(1, BASE + 32'h00, 4'b0011, 32'hAABB_CCDD, "sig_be");
        chk("sig_be.const", sig, 32'h0000_CCDD);
        xact(1, BASE + 32'h04, 4'hF, 32'h0, "clr2");

        // Error cases leave state untouched
        xact(1, BASE + 32'h00, 4'hF, 32'h8000_0003, "sig3");
        xact(0, BASE + 32'h18, 4'hF, 32'h0, "unmapped");
        xact(1, BASE + 32'h14, 4'hF, 32'h1111_1111, "wr_cycle");
        xact(1, BASE + 32'h02, 4'hF, 32'h2222_2222, "misalign");
        xact(0, BASE + 32'h04, 4'hF, 32'h0, "rd_clr");
        xact(1, BASE + 32'h0C, 4'hF, 32'h3, "wr_tstamp");
        xact(0, BASE + 32'h14, 4'hF, 32'h0, "rd_cycle");

        // Checkpoint timestamp
        xact(1, BASE + 32'h08, 4'hF, 32'h0, "ckpt1");
        xact(1, BASE + 32'h08, 4'hF, 32'h0, "ckpt2");
        xact(0, BASE + 32'h0C, 4'hF, 32'h0, "rd_tstamp");

        // Sticky exit
        xact(1, BASE + 32'h10, 4'hF, 32'h0, "exit0");
        xact(1, BASE + 32'h10, 4'hF, 32'h5, "exit5");
        chk("exit5.val", exval, 32'h0);
        xact(0, BASE + 32'h10, 4'hF, 32'h0, "rd_exit");

        // Four back-to-back writes: gnt every cycle, rvalid on four consecutive cycles
        for (int k = 0; k < 4; k++) begin
            logic e;
            logic [31:0] rd, d;
            @(negedge clk);
            d = $urandom;
            req = 1; we = 1; addr = BASE; be = 4'hF; wdata = d;
            #1;
            chk("b2b.gnt", {31'h0, gnt}, 32'h1);
            if (k > 0) chk("b2b.rvalid", {31'h0, rvalid}, 32'h1);
            model_xact(1, BASE, 4'hF, d, tb_cyc, e, rd);
        end
        @(posedge clk);
        #1 req = 0; we = 0; addr = 0; wdata = 0; be = 0;
        @(negedge clk);
        chk("b2b.last_rvalid", {31'h0, rvalid}, 32'h1);
        chk("b2b.sig", sig, m_sig);
        @(negedge clk);
        chk("b2b.idle_rvalid", {31'h0, rvalid}, 32'h0);
        chk("b2b.idle_rdata", rdata, 32'h0);

        // Random traffic over mapped, unmapped and misaligned offsets
        offs = '{32'h00, 32'h00, 32'h04, 32'h08, 32'h0C, 32'h10,
                 32'h14, 32'h18, 32'h3C, 32'h02, 32'h40, 32'h11};
        for (int n = 0; n < 40; n++)
            xact(1'($urandom), BASE + offs[$urandom_range(11)], 4'($urandom), $urandom, "rand");

        // GNT_WAIT=3: gnt three cycles after req, rvalid one cycle later
        @(negedge clk);
        req1 = 1; addr1 = BASE + 32'h14; we1 = 0; be1 = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1 chk("w3.nognt", {31'h0, gnt1}, 32'h0);
            @(negedge clk);
        end
        #1 chk("w3.gnt", {31'h0, gnt1}, 32'h1);
        cyc = tb_cyc;
        @(posedge clk);
        #1 req1 = 0;
        @(negedge clk);
        chk("w3.rvalid", {31'h0, rvalid1}, 32'h1);
        chk("w3.rdata", rdata1, cyc);
        chk("w3.err", {31'h0, err1}, 32'h0);

        // Request withdrawn during wait: no grant, no response
        @(negedge clk);
        req1 = 1; addr1 = BASE + 32'h10; we1 = 1; wdata1 = 32'h77;
        #1 chk("abort.nognt0", {31'h0, gnt1}, 32'h0);
        @(negedge clk);
        req1 = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort.gnt", {31'h0, gnt1}, 32'h0);
            chk("abort.rvalid", {31'h0, rvalid1}, 32'h0);
        end
        chk("abort.exv", {31'h0, exv1}, 32'h0);

        // Reset between gnt and rvalid discards the response
        @(negedge clk);
        req = 1; we = 1; addr = BASE; be = 4'hF; wdata = 32'hCAFE_F00D;
        #1 chk("midrst.gnt", {31'h0, gnt}, 32'h1);
        @(posedge clk);
        #1 rst_n = 0; req = 0; we = 0; addr = 0; wdata = 0; be = 0;
        model_reset();
        @(negedge clk);
        chk("midrst.rvalid", {31'h0, rvalid}, 32'h0);
        #2 rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postrst.rvalid", {31'h0, rvalid}, 32'h0);
            chk("postrst.err", {31'h0, err}, 32'h0);
            chk("postrst.rdata", rdata, 32'h0);
            check_state("postrst");
        end
        xact(0, BASE + 32'h14, 4'hF, 32'h0, "postrst_cycle");
        xact(0, BASE + 32'h0C, 4'hF, 32'h0, "postrst_tstamp");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
